// File: rtl/hex_matrix_scan.sv
// hex_matrix_scan: row-multiplexed 5x7 LED scan showing one byte as two 3x5 hex glyphs,
// with per-row PWM brightness and byte/brightness updates applied only at frame boundaries.
//
// state | meaning
// BLANK | display dark, waiting for the first byte
// SCAN  | cycling rows 0..4, ROW_DWELL cycles per row slot
module hex_matrix_scan #(
  parameter int ROW_DWELL = 50000,
  parameter int BRIGHT_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic [7:0]          glyph_byte,
  input  logic [14:0]         glyph_left,
  input  logic [14:0]         glyph_right,
  output logic [4:0]          row_n,
  output logic [6:0]          col,
  output logic                frame_start
);

  localparam int CW   = $clog2(ROW_DWELL);
  localparam int STEP = ROW_DWELL / 16;
  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW-1:0] LAST   = CW'(ROW_DWELL - 1);

  typedef enum logic {BLANK, SCAN} state_t;

  state_t              state, state_d;
  logic [CW-1:0]       dwell_cnt, dwell_d;
  logic [2:0]          row_idx, row_d;
  logic [7:0]          glyph_d;
  logic [BRIGHT_W-1:0] bright_l, bright_d;
  logic                pend_vld, pend_vld_d;
  logic [7:0]          pend_byte, pend_byte_d;
  logic                frame_start_d;
  logic [4:0]          row_n_d;
  logic [6:0]          col_d;

  logic                hs;
  logic                last_dwell;
  logic                on_next;
  logic [CW:0]         on_lim;
  logic [CW:0]         dwell_inc;
  logic [2:0]          left_grp, right_grp;

  assign data_ready = ~pend_vld;
  assign hs         = data_valid & data_ready;
  assign last_dwell = (dwell_cnt == LAST);
  assign dwell_inc  = {1'b0, dwell_cnt} + (CW+1)'(1);
  assign on_lim     = ((CW+1)'(bright_l) + (CW+1)'(1)) * STEP_W;

  // Drive is registered from the next slot position, so the output lines up with
  // dwell_cnt and slot cycle 0 (row/glyph/brightness change point) is always dark.
  assign on_next = (state == SCAN) && !last_dwell && (dwell_inc < on_lim);

  always_comb begin
    left_grp  = 3'b000;
    right_grp = 3'b000;
    case (row_idx)
      3'd0: begin left_grp = glyph_left[14:12]; right_grp = glyph_right[14:12]; end
      3'd1: begin left_grp = glyph_left[11:9];  right_grp = glyph_right[11:9];  end
      3'd2: begin left_grp = glyph_left[8:6];   right_grp = glyph_right[8:6];   end
      3'd3: begin left_grp = glyph_left[5:3];   right_grp = glyph_right[5:3];   end
      3'd4: begin left_grp = glyph_left[2:0];   right_grp = glyph_right[2:0];   end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state;
    dwell_d       = dwell_cnt;
    row_d         = row_idx;
    glyph_d       = glyph_byte;
    bright_d      = bright_l;
    pend_vld_d    = pend_vld;
    pend_byte_d   = pend_byte;
    frame_start_d = 1'b0;
    row_n_d       = 5'h1F;
    col_d         = 7'd0;
    case (state)
      BLANK: begin
        if (hs) begin
          state_d       = SCAN;
          glyph_d       = data_in;
          bright_d      = brightness;
          row_d         = 3'd0;
          dwell_d       = '0;
          frame_start_d = 1'b1;
        end
      end
      SCAN: begin
        if (last_dwell) begin
          dwell_d = '0;
          if (row_idx == 3'd4) begin
            row_d         = 3'd0;
            frame_start_d = 1'b1;
            bright_d      = brightness;
            if (pend_vld) begin
              glyph_d    = pend_byte;
              pend_vld_d = 1'b0;
            end
          end else begin
            row_d = row_idx + 3'd1;
          end
        end else begin
          dwell_d = dwell_inc[CW-1:0];
        end
        // hs implies pend_vld==0, so this never collides with the boundary clear
        if (hs) begin
          pend_byte_d = data_in;
          pend_vld_d  = 1'b1;
        end
        if (on_next) begin
          row_n_d = ~(5'b00001 << row_idx);
          col_d   = {right_grp, 1'b0, left_grp};
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK;
      dwell_cnt   <= '0;
      row_idx     <= 3'd0;
      glyph_byte  <= 8'd0;
      bright_l    <= '0;
      pend_vld    <= 1'b0;
      pend_byte   <= 8'd0;
      frame_start <= 1'b0;
      row_n       <= 5'h1F;
      col         <= 7'd0;
    end else begin
      state       <= state_d;
      dwell_cnt   <= dwell_d;
      row_idx     <= row_d;
      glyph_byte  <= glyph_d;
      bright_l    <= bright_d;
      pend_vld    <= pend_vld_d;
      pend_byte   <= pend_byte_d;
      frame_start <= frame_start_d;
      row_n       <= row_n_d;
      col         <= col_d;
    end
  end

endmodule

// File: tb/tb_hex_matrix_scan.sv
// Scoreboard bench for hex_matrix_scan: a frame-level model pushes the expected byte and
// brightness of each frame; a monitor checks every row/column cycle of each frame.
module tb_hex_matrix_scan;

  localparam int RD    = 32;
  localparam int FRAME = 5 * RD;
  localparam int NFR   = 30;
  localparam int NCYC  = 4 + FRAME * NFR + 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  data_in = 8'd0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [3:0]  brightness = 4'd0;
  logic [7:0]  glyph_byte;
  logic [14:0] glyph_left, glyph_right;
  logic [4:0]  row_n;
  logic [6:0]  col;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] b;
    logic [3:0] br;
  } frame_t;
  frame_t exp_q[$];

  always #5 clk = ~clk;

  hex_matrix_scan #(.ROW_DWELL(RD), .BRIGHT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .brightness(brightness), .glyph_byte(glyph_byte),
    .glyph_left(glyph_left), .glyph_right(glyph_right), .row_n(row_n), .col(col),
    .frame_start(frame_start)
  );

  // Glyphs written as they look: each 3-bit row with the leftmost pixel as the MSB.
  function automatic logic [14:0] font_vis(input logic [3:0] n);
    case (n)
      4'h0: return 15'b111_101_101_101_111;
      4'h1: return 15'b010_110_010_010_111;
      4'h2: return 15'b111_001_111_100_111;
      4'h3: return 15'b111_001_111_001_111;
      4'h4: return 15'b101_101_111_001_001;
      4'h5: return 15'b111_100_111_001_111;
      4'h6: return 15'b111_100_111_101_111;
      4'h7: return 15'b111_001_001_001_001;
      4'h8: return 15'b111_101_111_101_111;
      4'h9: return 15'b111_101_111_001_111;
      4'hA: return 15'b111_101_111_101_101;
      4'hB: return 15'b110_101_110_101_110;
      4'hC: return 15'b111_100_100_100_111;
      4'hD: return 15'b110_101_101_101_110;
      4'hE: return 15'b111_100_111_100_111;
      default: return 15'b111_100_111_100_100;
    endcase
  endfunction

  function automatic logic pix(input logic [3:0] n, input int r, input int k);
    logic [14:0] v;
    v = font_vis(n);
    return v[14 - 3*r - k];
  endfunction

  // Decoder bitmap: row r in bits [14-3r -: 3], bit k of the group = column k.
  function automatic logic [14:0] dec(input logic [3:0] n);
    logic [14:0] g;
    g = '0;
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 3; k++)
        g[12 - 3*r + k] = pix(n, r, k);
    return g;
  endfunction

  assign glyph_left  = dec(glyph_byte[7:4]);
  assign glyph_right = dec(glyph_byte[3:0]);

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(~row_n) > 1 || (dut.dwell_cnt == 0 && row_n !== 5'h1F)) begin
        errors++;
        $display("FAIL invariant t=%0t row_n=%b dwell=%0d", $time, row_n, dut.dwell_cnt);
      end
    end
  end

  task automatic drive();
    int t;
    bit started, m_pend, rnd;
    logic [7:0] m_disp, m_pendb;
    logic [3:0] m_br;
    logic [7:0] sendq[$];
    logic hs;
    started = 0; m_pend = 0; t = 0; m_disp = 8'd0; m_pendb = 8'd0; m_br = 4'd0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      checks++;
      if (data_ready !== !m_pend) begin
        errors++;
        $display("FAIL data_ready cycle=%0d got=%b exp=%b", c, data_ready, !m_pend);
      end
      rnd = started && (t >= 800);
      if (c == 3) begin sendq.push_back(8'h3A); brightness = 4'd15; end
      if (started) begin
        if (t == 70)  sendq.push_back(8'hF0);
        if (t == 170) begin sendq.push_back(8'h11); sendq.push_back(8'h22); end
        if (t == 400) brightness = 4'd0;
        if (t == 560) brightness = 4'd7;
        if (rnd && $urandom_range(0, 49) == 0) brightness = 4'($urandom);
      end
      if (sendq.size() > 0) begin
        data_valid = 1'b1; data_in = sendq[0];
      end else if (rnd && $urandom_range(0, 15) == 0) begin
        data_valid = 1'b1;
        data_in = ($urandom_range(0, 3) == 0) ? m_disp : 8'($urandom);
      end else begin
        data_valid = 1'b0; data_in = 8'($urandom);
      end
      hs = data_valid && !m_pend;
      if (!started) begin
        if (hs) begin
          started = 1; t = 0; m_disp = data_in; m_br = brightness;
          exp_q.push_back('{b: m_disp, br: m_br});
        end
      end else begin
        t++;
        if (t % FRAME == 0) begin
          if (m_pend) begin m_disp = m_pendb; m_pend = 0; end
          m_br = brightness;
          exp_q.push_back('{b: m_disp, br: m_br});
        end
        if (hs) begin m_pendb = data_in; m_pend = 1; end
      end
      if (hs && sendq.size() > 0) void'(sendq.pop_front());
    end
    data_valid = 1'b0;
  endtask

  task automatic monitor();
    frame_t e;
    int waited, r, d;
    bit on;
    logic [4:0] er;
    logic [6:0] ec;
    waited = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && waited < 1000) begin @(negedge clk); waited++; end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("FAIL first_frame_start timeout got=%b exp=1", frame_start);
      return;
    end
    for (int f = 0; f < NFR; f++) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_queue frame=%0d got=empty exp=entry", f);
        return;
      end
      e = exp_q.pop_front();
      checks++;
      if (glyph_byte !== e.b) begin
        errors++;
        $display("FAIL glyph_byte frame=%0d got=%h exp=%h", f, glyph_byte, e.b);
      end
      for (int i = 0; i < FRAME; i++) begin
        r = i / RD; d = i % RD;
        on = (d != 0) && (d < (int'(e.br) + 1) * (RD / 16));
        er = on ? ~(5'b00001 << r) : 5'h1F;
        ec = 7'd0;
        if (on)
          for (int k = 0; k < 3; k++) begin
            ec[k]     = pix(e.b[7:4], r, k);
            ec[4 + k] = pix(e.b[3:0], r, k);
          end
        checks++;
        if (row_n !== er || col !== ec) begin
          errors++;
          $display("FAIL drive frame=%0d row=%0d dwell=%0d got row_n=%b col=%b exp row_n=%b col=%b",
                   f, r, d, row_n, col, er, ec);
        end
        checks++;
        if (frame_start !== (i == 0)) begin
          errors++;
          $display("FAIL frame_start frame=%0d i=%0d got=%b exp=%b", f, i, frame_start, (i == 0));
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    int waited;
    repeat (3) @(negedge clk);
    checks++;
    if (row_n !== 5'h1F || col !== 7'd0 || glyph_byte !== 8'd0 || data_ready !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got row_n=%b col=%b byte=%h rdy=%b fs=%b", row_n, col, glyph_byte, data_ready, frame_start);
    end
    rst_n = 1'b1;
    fork
      drive();
      monitor();
    join

    @(negedge clk); data_valid = 1'b1; data_in = 8'h5C;
    @(negedge clk); data_valid = 1'b0;
    waited = 0;
    while (row_n === 5'h1F && waited < 400) begin @(negedge clk); waited++; end
    checks++;
    if (row_n === 5'h1F) begin
      errors++;
      $display("FAIL lit_before_reset timeout got row_n=%b exp=lit", row_n);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (row_n !== 5'h1F || col !== 7'd0 || glyph_byte !== 8'd0 || data_ready !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got row_n=%b col=%b byte=%h rdy=%b fs=%b exp 11111/0/00/1/0",
               row_n, col, glyph_byte, data_ready, frame_start);
    end
    @(negedge clk); rst_n = 1'b1;
    waited = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (row_n !== 5'h1F || frame_start !== 1'b0) waited++;
    end
    checks++;
    if (waited != 0) begin
      errors++;
      $display("FAIL blank_after_reset got=%0d active cycles exp=0", waited);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
